q_rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 4:1 single-bit data mux among four requesters and drives its 2-bit select. Each requester holds ownership until it signals completion. A Q-channel low-power handshake lets the power controller quiesce the block: it grants the request only when no transfer is in flight and no request is pending, and denies it otherwise. The block sits between the requesters and the mux select, with the Q-channel port facing the power controller.

---
 rtl/q_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/q_rr_mux_arbiter.sv | 108 ++++++++++
 tb/tb_q_rr_mux_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/q_arb_pkg.sv
// Shared sizing and Q-channel state encoding for the round-robin mux arbiter.
package q_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    Q_RUN,
    Q_REQUEST,
    Q_STOPPED,
    Q_DENIED
  } q_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first unmasked request after 'last', wrapping.
module rr_pick
  import q_arb_pkg::*;
#(
  parameter int RP_NUM = NUM_REQ,
  parameter int RP_SEL = $clog2(RP_NUM)
) (
  input  logic [RP_NUM-1:0] req,
  input  logic [RP_NUM-1:0] mask,
  input  logic [RP_SEL-1:0] last,
  output logic [RP_NUM-1:0] pick,
  output logic [RP_SEL-1:0] idx,
  output logic              any
);

  logic [RP_NUM-1:0] cand;
  logic [RP_SEL-1:0] c;

  always_comb begin
    cand = req & ~mask;
    idx  = '0;
    any  = 1'b0;
    c    = '0;
    // scan last+1 .. last+RP_NUM so 'last' itself is visited last
    for (int k = 1; k <= RP_NUM; k++) begin
      c = RP_SEL'((int'(last) + k) % RP_NUM);
      if (!any && cand[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
    pick = any ? (RP_NUM'(1) << idx) : '0;
  end

endmodule

// File: rtl/q_rr_mux_arbiter.sv
// Round-robin owner of a shared 4:1 mux select, with a Q-channel quiesce handshake
// that accepts only when nothing is owned or pending.
module q_rr_mux_arbiter
  import q_arb_pkg::*;
#(
  parameter int NUM_REQ = q_arb_pkg::NUM_REQ,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [SEL_W-1:0]   sel_o,
  output logic               busy_o,
  input  logic               qreqn_i,
  output logic               qacceptn_o,
  output logic               qdeny_o,
  output logic               qactive_o
);

  q_state_e           state, nxt_state;
  logic [SEL_W-1:0]   last, nxt_last;
  logic [NUM_REQ-1:0] nxt_grant;
  logic [SEL_W-1:0]   nxt_sel;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] pick;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               rel;

  // The releasing owner is masked so a held req_i cannot win the same edge again.
  assign rel  = busy_o & done_i;
  assign mask = rel ? grant_o : '0;

  rr_pick #(
    .RP_NUM (NUM_REQ),
    .RP_SEL (SEL_W)
  ) u_pick (
    .req  (req_i),
    .mask (mask),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign qactive_o = (|req_i) | busy_o;

  always_comb begin
    nxt_state = state;
    nxt_grant = grant_o;
    nxt_sel   = sel_o;
    nxt_last  = last;
    case (state)
      Q_RUN: begin
        if (!qreqn_i) begin
          // quiesce request wins over arbitration; a release is still honoured
          nxt_state = Q_REQUEST;
          if (rel) begin
            nxt_grant = '0;
            nxt_sel   = '0;
          end
        end else if (!busy_o || rel) begin
          if (pick_any) begin
            nxt_grant = pick;
            nxt_sel   = pick_idx;
            nxt_last  = pick_idx;
          end else begin
            nxt_grant = '0;
            nxt_sel   = '0;
          end
        end
      end
      Q_REQUEST: begin
        if (!busy_o || rel) begin
          nxt_grant = '0;
          nxt_sel   = '0;
          nxt_state = pick_any ? Q_DENIED : Q_STOPPED;
        end
      end
      Q_STOPPED: if (qreqn_i) nxt_state = Q_RUN;
      Q_DENIED:  if (qreqn_i) nxt_state = Q_RUN;
      default:   nxt_state = Q_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= Q_RUN;
      grant_o    <= '0;
      sel_o      <= '0;
      busy_o     <= 1'b0;
      last       <= SEL_W'(NUM_REQ - 1);
      qacceptn_o <= 1'b1;
      qdeny_o    <= 1'b0;
    end else begin
      state      <= nxt_state;
      grant_o    <= nxt_grant;
      sel_o      <= nxt_sel;
      busy_o     <= |nxt_grant;
      last       <= nxt_last;
      qacceptn_o <= (nxt_state != Q_STOPPED);
      qdeny_o    <= (nxt_state == Q_DENIED);
    end
  end

endmodule

// File: tb/tb_q_rr_mux_arbiter.sv
// Directed bench for q_rr_mux_arbiter: integer-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_q_rr_mux_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_i = '0;
  logic          done_i = 1'b0;
  logic          qreqn_i = 1'b1;
  logic [N-1:0]  grant_o;
  logic [SW-1:0] sel_o;
  logic          busy_o, qacceptn_o, qdeny_o, qactive_o;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  q_rr_mux_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .done_i(done_i),
    .grant_o(grant_o), .sel_o(sel_o), .busy_o(busy_o),
    .qreqn_i(qreqn_i), .qacceptn_o(qacceptn_o), .qdeny_o(qdeny_o),
    .qactive_o(qactive_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner as an integer (-1 = idle), Q phase as a small integer.
  localparam int M_RUN = 0, M_REQ = 1, M_STOP = 2, M_DENY = 3;
  int m_owner, m_last, m_q;

  function automatic int m_choose(input logic [N-1:0] r, input int own, input bit released, input int lst);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (lst + k) % N;
      if (r[c] && !(released && c == own)) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit released;
    int c;
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_q = M_RUN;
    end else begin
      released = (m_owner >= 0) && done_i;
      c = m_choose(req_i, m_owner, released, m_last);
      case (m_q)
        M_RUN:
          if (!qreqn_i) begin
            m_q = M_REQ;
            if (released) m_owner = -1;
          end else if (m_owner < 0 || released) begin
            m_owner = c;
            if (c >= 0) m_last = c;
          end
        M_REQ:
          if (m_owner < 0 || released) begin
            m_owner = -1;
            m_q = (c >= 0) ? M_DENY : M_STOP;
          end
        default: if (qreqn_i) m_q = M_RUN;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", 32'(grant_o), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("sel", 32'(sel_o), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk("busy", 32'(busy_o), 32'(m_owner >= 0));
      chk("qacceptn", 32'(qacceptn_o), 32'(m_q != M_STOP));
      chk("qdeny", 32'(qdeny_o), 32'(m_q == M_DENY));
      chk("qactive", 32'(qactive_o), 32'((|req_i) || (m_owner >= 0)));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    int seq [5];
    seq = '{0, 1, 2, 3, 0};

    #1 rst_n = 1'b0;
    #21;
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_sel", 32'(sel_o), 0);
    chk("rst_qacceptn", 32'(qacceptn_o), 1);
    chk("rst_qdeny", 32'(qdeny_o), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // round robin over all four with back-to-back handovers
    step();
    req_i = 4'b1111;
    step();
    chk("rr_first", 32'(grant_o), 32'b0001);
    for (int i = 1; i < 5; i++) begin
      done_i = 1'b1;
      step();
      done_i = 1'b0;
      chk("rr_grant", 32'(grant_o), 32'd1 << seq[i]);
      chk("rr_sel", 32'(sel_o), 32'(seq[i]));
    end
    req_i = '0; done_i = 1'b1; step(); done_i = 1'b0;
    chk("rr_idle", 32'(busy_o), 0);

    // wrap-around: owner 2 releases, 0 is next and 2 is not regranted
    req_i = 4'b0100; step();
    chk("wrap_own2", 32'(grant_o), 32'b0100);
    req_i = 4'b0101; done_i = 1'b1; step(); done_i = 1'b0;
    chk("wrap_to0", 32'(grant_o), 32'b0001);
    chk("wrap_sel", 32'(sel_o), 0);
    req_i = '0; done_i = 1'b1; step(); done_i = 1'b0;

    // idle quiesce: accept two edges after qreqn falls
    qreqn_i = 1'b0; step();
    chk("qidle_req", 32'(qacceptn_o), 1);
    step();
    chk("qidle_acc", 32'(qacceptn_o), 0);
    req_i = 4'b0010; step();
    chk("qstop_nogrant", 32'(grant_o), 0);
    chk("qstop_active", 32'(qactive_o), 1);
    step();
    chk("qstop_nogrant2", 32'(grant_o), 0);
    qreqn_i = 1'b1; step();
    chk("qexit_acc", 32'(qacceptn_o), 1);
    chk("qexit_nogrant", 32'(grant_o), 0);
    step();
    chk("qexit_grant1", 32'(grant_o), 32'b0010);

    // busy quiesce with a pending request ends in deny
    req_i = 4'b1010; qreqn_i = 1'b0; step();
    chk("qbusy_hold", 32'(grant_o), 32'b0010);
    step();
    chk("qbusy_hold2", 32'(grant_o), 32'b0010);
    done_i = 1'b1; step(); done_i = 1'b0;
    chk("qbusy_deny", 32'(qdeny_o), 1);
    chk("qbusy_rel", 32'(grant_o), 0);
    req_i = 4'b1000; qreqn_i = 1'b1; step();
    chk("qdeny_clr", 32'(qdeny_o), 0);
    chk("qdeny_nogrant", 32'(grant_o), 0);
    step();
    chk("qdeny_grant3", 32'(grant_o), 32'b1000);
    chk("qdeny_sel3", 32'(sel_o), 3);

    // asynchronous reset mid-transfer
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    chk("arst_grant", 32'(grant_o), 0);
    chk("arst_sel", 32'(sel_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_qacceptn", 32'(qacceptn_o), 1);
    chk("arst_qdeny", 32'(qdeny_o), 0);
    rst_n = 1'b1;
    step();
    chk("arst_grant3", 32'(grant_o), 32'b1000);
    chk("arst_sel3", 32'(sel_o), 3);
    req_i = '0; done_i = 1'b1; step(); done_i = 1'b0;

    // qreqn falling together with a request on an idle arbiter: deny, no grant
    req_i = 4'b0100; qreqn_i = 1'b0; step();
    chk("qsim_nogrant", 32'(grant_o), 0);
    step();
    chk("qsim_deny", 32'(qdeny_o), 1);
    chk("qsim_nogrant2", 32'(grant_o), 0);
    qreqn_i = 1'b1; step();
    chk("qsim_clr", 32'(qdeny_o), 0);
    step();
    chk("qsim_grant2", 32'(grant_o), 32'b0100);
    chk("qsim_sel2", 32'(sel_o), 2);

    // done while idle is ignored
    req_i = '0; done_i = 1'b1; step(); done_i = 1'b0;
    done_i = 1'b1; step(); done_i = 1'b0;
    chk("idle_done", 32'(grant_o), 0);
    step();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
